bus_mux_arbiter_8: RTL



---
 rtl/bus_mux_arbiter_8_pkg.sv | 18 +
 rtl/bus_mux_arbiter_8_if.sv | 13 +
 rtl/bus_mux_arbiter_8_rr_pick8.sv | 26 ++
 rtl/bus_mux_arbiter_8.sv | 97 +++++++++
 4 files changed

// File: rtl/bus_mux_arbiter_8_pkg.sv
// Shared types and constants for the 8-source bus mux arbiter family.
package bus_arb_pkg;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // One-hot decode of a source index.
    function automatic logic [NUM_SRC-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        return NUM_SRC'(1) << s;
    endfunction

endpackage

// File: rtl/bus_mux_arbiter_8_if.sv
// Request/grant/select bundle between requesters and the bus mux arbiter.
interface bus_mux_arbiter_8_if;
    import bus_arb_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;

    modport master (output req, input gnt, input sel, input busy);
    modport slave  (input req, output gnt, output sel, output busy);

endinterface

// File: rtl/bus_mux_arbiter_8_rr_pick8.sv
// Combinational round-robin picker: first set req bit after index 'last', wrapping.
module rr_pick8
    import bus_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        any    = |req;
        idx    = last;
        w_cand = last;
        for (int k = int'(NUM_SRC); k > 0; k--) begin
            w_cand = last + SEL_W'(k);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_mux_arbiter_8.sv
// Round-robin bus arbiter with hold timeout and one dead cycle between owners;
// drives the one-hot grant and 3-bit select of a downstream 8:1 mux.
module bus_mux_arbiter_8
    import bus_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic               sysclk,
    input  logic               sys_rst_n,
    bus_mux_arbiter_8_if.slave bus
);

    localparam int unsigned CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_any;
    logic [SEL_W-1:0] w_idx;
    logic             w_owner_req;
    logic             w_others;
    logic             w_timeout;

    rr_pick8 u_pick (
        .req  (bus.req),
        .last (r_last),
        .any  (w_any),
        .idx  (w_idx)
    );

    assign w_owner_req = bus.req[r_sel];
    assign w_others    = |(bus.req & ~sel_to_onehot(r_sel));
    assign w_timeout   = (HOLD_MAX != 0) && (r_cnt == CNT_W'(HOLD_MAX - 1));

    // State register.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_any) w_state_nxt = ST_GRANT;
            ST_GRANT:   if (!w_owner_req || (w_timeout && w_others)) w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = w_any ? ST_GRANT : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the output, priority and hold-counter registers.
    always_comb begin
        w_valid_nxt = (w_state_nxt == ST_GRANT);
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        if ((r_state != ST_GRANT) && (w_state_nxt == ST_GRANT)) begin
            w_sel_nxt  = w_idx;
            w_last_nxt = w_idx;
            w_cnt_nxt  = '0;
        end else if ((r_state == ST_GRANT) && (r_cnt != CNT_W'(HOLD_MAX))) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Output and bookkeeping registers; reset makes source 0 first in line.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_last  <= SEL_W'(NUM_SRC - 1);
            r_cnt   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.gnt  = sel_to_onehot(r_sel) & {NUM_SRC{r_valid}};
    assign bus.sel  = r_sel;
    assign bus.busy = r_valid;

endmodule
